// File: rtl/ls_err_cnt_mc.sv
// ---------------------------------------------------------------------------
// ls_err_cnt_mc
// Multi-lane shift-register error counter. Each lane waits for a rising edge
// on its DUT output Q, aligns its expected-data stream DATA by a programmable
// delay, compares Q against the aligned DATA bit-by-bit once aligned DATA
// goes high, and keeps a saturating mismatch count.
//
// Ports
//   CLK       in   system clock, all logic on posedge
//   RST       in   synchronous active-high reset
//   EN        in   arm/run; low returns every lane to IDLE
//   CLR_CNT   in   one-cycle pulse, clears counters, SAT and TMO_FLAG
//   DLY_SEL   in   DATA alignment delay (cycles), shared by all lanes
//   Q         in   DUT outputs, one bit per lane
//   DATA      in   expected data, one bit per lane
//   ERR_CNT   out  lane i count at [i*CNT_W +: CNT_W]
//   SAT       out  sticky, lane counter reached all-ones
//   LOCKED    out  lane is in COMPARE
//   TMO_FLAG  out  sticky, lane timed out waiting in SYNCED
//   ERR_ANY   out  OR of all lanes' registered mismatch pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ls_err_cnt_mc #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 12,
  parameter int DLY_MAX = 8,
  parameter int TMO     = 255
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic                       CLR_CNT,
  input  logic [$clog2(DLY_MAX)-1:0] DLY_SEL,
  input  logic [NCH-1:0]             Q,
  input  logic [NCH-1:0]             DATA,
  output logic [NCH*CNT_W-1:0]       ERR_CNT,
  output logic [NCH-1:0]             SAT,
  output logic [NCH-1:0]             LOCKED,
  output logic [NCH-1:0]             TMO_FLAG,
  output logic                       ERR_ANY
);

  localparam int DSEL_W = $clog2(DLY_MAX);
  localparam int WCNT_W = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_SYNCED  = 2'd2;
  localparam logic [1:0] S_COMPARE = 2'd3;

  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Saturating increment: all-ones is sticky.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [NCH-1:0]    q_p1, q_p2, q_p3;
  logic [NCH-1:0]    dline [DLY_MAX];
  logic [NCH-1:0]    da_p2;
  logic [DSEL_W-1:0] dly_r;
  logic [1:0]        state [NCH];
  logic [WCNT_W-1:0] wcnt  [NCH];
  logic [NCH-1:0]    err_p3;
  logic [CNT_W-1:0]  cnt   [NCH];
  logic [NCH-1:0]    sat_r, tmo_r;

  logic [NCH-1:0]    edge_det;
  logic [1:0]        nxt_state [NCH];
  logic [WCNT_W-1:0] nxt_wcnt  [NCH];
  logic [NCH-1:0]    tmo_hit;
  logic [NCH-1:0]    cmp_act;
  logic              all_idle;

  assign edge_det = q_p2 & ~q_p3;

  always_comb begin : idle_chk
    all_idle = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (state[i] != S_IDLE) all_idle = 1'b0;
    end
  end

  always_comb begin : fsm_next
    for (int i = 0; i < NCH; i++) begin
      nxt_state[i] = state[i];
      nxt_wcnt[i]  = wcnt[i];
      tmo_hit[i]   = 1'b0;
      if (!EN) begin
        nxt_state[i] = S_IDLE;
      end else begin
        case (state[i])
          S_IDLE:  nxt_state[i] = S_ARMED;
          // An edge coinciding with da=1 only syncs; da is looked at again next cycle.
          S_ARMED: begin
            if (edge_det[i]) begin
              nxt_state[i] = S_SYNCED;
              nxt_wcnt[i]  = '0;
            end
          end
          S_SYNCED: begin
            if (da_p2[i]) begin
              nxt_state[i] = S_COMPARE;
            end else if (wcnt[i] == WCNT_LAST) begin
              nxt_state[i] = S_ARMED;
              tmo_hit[i]   = 1'b1;
            end else begin
              nxt_wcnt[i] = wcnt[i] + WCNT_ONE;
            end
          end
          default: ;
        endcase
      end
      // The SYNCED->COMPARE cycle already compares. A lane still in COMPARE
      // while EN drops compares one last time so an in-flight error is kept.
      cmp_act[i] = (state[i] == S_COMPARE) |
                   (EN & (state[i] == S_SYNCED) & da_p2[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_p1  <= '0;
      q_p2  <= '0;
      q_p3  <= '0;
      for (int k = 0; k < DLY_MAX; k++) dline[k] <= '0;
      da_p2  <= '0;
      dly_r  <= '0;
      err_p3 <= '0;
      sat_r  <= '0;
      tmo_r  <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= S_IDLE;
        wcnt[i]  <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      // Stage p1..p3: Q input synchronizer and edge history
      q_p1 <= Q;
      q_p2 <= q_p1;
      q_p3 <= q_p2;

      // Stage p2: DATA line; the tap plus the output flop gives DLY_SEL+2 cycles
      dline[0] <= DATA;
      for (int k = 1; k < DLY_MAX; k++) dline[k] <= dline[k-1];
      da_p2 <= dline[dly_r];
      if (all_idle) dly_r <= DLY_SEL;

      // Stage p3: per-lane state, registered mismatch, counters
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= nxt_state[i];
        wcnt[i]   <= nxt_wcnt[i];
        err_p3[i] <= cmp_act[i] & (q_p2[i] ^ da_p2[i]);
        if (CLR_CNT) begin
          cnt[i]   <= '0;
          sat_r[i] <= 1'b0;
          tmo_r[i] <= 1'b0;
        end else begin
          if (err_p3[i]) begin
            cnt[i] <= sat_inc(cnt[i]);
            if (&sat_inc(cnt[i])) sat_r[i] <= 1'b1;
          end
          if (tmo_hit[i]) tmo_r[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin : outs
    for (int i = 0; i < NCH; i++) begin
      ERR_CNT[i*CNT_W +: CNT_W] = cnt[i];
      LOCKED[i]                 = (state[i] == S_COMPARE);
    end
  end

  assign SAT      = sat_r;
  assign TMO_FLAG = tmo_r;
  assign ERR_ANY  = |err_p3;

endmodule
